// File: rtl/chunk_pkg.sv
// ============================================================================
// chunk_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the chunk write path (transmitter and receiving
// chunk buffer): beat/count widths, FSM state encoding and chunk image types.
// No ports (package).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef MEM_SIZE
`define MEM_SIZE 512
`endif
`ifndef BUS_SIZE
`define BUS_SIZE 128
`endif

package chunk_pkg;

  // Beats per chunk and derived counter widths.
  localparam int BEAT_NUM = `MEM_SIZE / `BUS_SIZE;
  localparam int CNT_W    = $clog2(BEAT_NUM);
  // One extra value so an all-ones sparsemap (MEM_SIZE set bits) fits.
  localparam int NZC_W    = $clog2(`MEM_SIZE + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  typedef logic [`MEM_SIZE-1:0]     sparsemap_t;
  // Compacted nonzero bytes, 1-based to match sparsemap rank numbering.
  typedef logic [`MEM_SIZE:1][7:0]  chunk_data_t;

endpackage

`default_nettype wire

// File: rtl/popcount_tree.sv
// ============================================================================
// popcount_tree
// ----------------------------------------------------------------------------
// Counts set bits of a WIDTH-bit vector with a balanced adder tree built by
// recursive halving. Purely combinational.
// Ports:
//   bits   in   [WIDTH-1:0]            vector to count
//   count  out  [$clog2(WIDTH+1)-1:0]  number of ones in bits
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module popcount_tree #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]           bits,
  output logic [$clog2(WIDTH+1)-1:0] count
);

  localparam int OUT_W = $clog2(WIDTH + 1);

  generate
    if (WIDTH == 1) begin : g_leaf
      assign count = bits;
    end else begin : g_split
      // Uneven widths put the extra bit in the upper half.
      localparam int LO_N = WIDTH / 2;
      localparam int HI_N = WIDTH - LO_N;

      logic [$clog2(LO_N+1)-1:0] lo_count;
      logic [$clog2(HI_N+1)-1:0] hi_count;

      popcount_tree #(.WIDTH(LO_N)) u_lo (
        .bits  (bits[LO_N-1:0]),
        .count (lo_count)
      );

      popcount_tree #(.WIDTH(HI_N)) u_hi (
        .bits  (bits[WIDTH-1:LO_N]),
        .count (hi_count)
      );

      assign count = OUT_W'(lo_count) + OUT_W'(hi_count);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/dat_chunk_tx.sv
// ============================================================================
// dat_chunk_tx
// ----------------------------------------------------------------------------
// Transmit side of the chunk write interface. Captures a whole compressed
// chunk image (sparsemap + compacted nonzero bytes) in one load handshake and
// streams it to the chunk combining buffer as MEM_SIZE/BUS_SIZE beats.
// Ports:
//   clk_i              in   clock
//   rst_i              in   synchronous active-high reset
//   ld_valid_i         in   chunk image offered
//   ld_ready_o         out  block can accept a chunk
//   ld_sparsemap_i     in   [MEM_SIZE-1:0] chunk sparsemap
//   ld_nonzero_data_i  in   [MEM_SIZE:1][7:0] compacted nonzero bytes
//   flush_i            in   abort current transfer
//   wr_ready_i         in   downstream accepts current beat
//   wr_valid_o         out  beat valid
//   wr_count_o         out  beat index
//   wr_sparsemap_o     out  [BUS_SIZE-1:0] sparsemap slice
//   wr_nonzero_data_o  out  [BUS_SIZE-1:0][7:0] nonzero-data slice
//   nz_count_o         out  popcount of the loaded sparsemap
//   done_o             out  one-cycle pulse after the last beat is accepted
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef MEM_SIZE
`define MEM_SIZE 512
`endif
`ifndef BUS_SIZE
`define BUS_SIZE 128
`endif

module dat_chunk_tx
  import chunk_pkg::*;
#(
  parameter int MEM_SIZE = `MEM_SIZE,
  parameter int BUS_SIZE = `BUS_SIZE
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     ld_valid_i,
  output logic                                     ld_ready_o,
  input  logic [MEM_SIZE-1:0]                      ld_sparsemap_i,
  input  logic [MEM_SIZE:1][7:0]                   ld_nonzero_data_i,
  input  logic                                     flush_i,
  input  logic                                     wr_ready_i,
  output logic                                     wr_valid_o,
  output logic [$clog2(MEM_SIZE/BUS_SIZE)-1:0]     wr_count_o,
  output logic [BUS_SIZE-1:0]                      wr_sparsemap_o,
  output logic [BUS_SIZE-1:0][7:0]                 wr_nonzero_data_o,
  output logic [$clog2(MEM_SIZE+1)-1:0]            nz_count_o,
  output logic                                     done_o
);

  localparam int BEATS    = MEM_SIZE / BUS_SIZE;
  localparam int CNT_BITS = $clog2(BEATS);
  localparam int NZC_BITS = $clog2(MEM_SIZE + 1);

  localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BEATS - 1);

  state_t                   state;
  logic [MEM_SIZE-1:0]      shadow_sm;
  logic [MEM_SIZE:1][7:0]   shadow_data;
  logic [NZC_BITS-1:0]      nz_sum;
  logic [CNT_BITS-1:0]      next_count;

  popcount_tree #(.WIDTH(MEM_SIZE)) u_popcount (
    .bits  (ld_sparsemap_i),
    .count (nz_sum)
  );

  assign next_count = wr_count_o + CNT_BITS'(1);

  // The wr_* slice registers are loaded one cycle ahead of the beat they
  // present: from the load inputs for beat 0, and from the shadow copy at
  // next_count on each accepted beat. They only change on acceptance, so
  // data is stable while valid is high and ready is low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state             <= IDLE;
      ld_ready_o        <= 1'b1;
      wr_valid_o        <= 1'b0;
      wr_count_o        <= '0;
      wr_sparsemap_o    <= '0;
      wr_nonzero_data_o <= '0;
      nz_count_o        <= '0;
      done_o            <= 1'b0;
      shadow_sm         <= '0;
      shadow_data       <= '0;
    end else begin
      done_o <= 1'b0;
      if (flush_i) begin
        // Abort wins over load and beat acceptance; image and popcount kept.
        state      <= IDLE;
        ld_ready_o <= 1'b1;
        wr_valid_o <= 1'b0;
        wr_count_o <= '0;
      end else begin
        case (state)
          IDLE: begin
            ld_ready_o <= 1'b1;
            if (ld_valid_i && ld_ready_o) begin
              shadow_sm         <= ld_sparsemap_i;
              shadow_data       <= ld_nonzero_data_i;
              nz_count_o        <= nz_sum;
              wr_sparsemap_o    <= ld_sparsemap_i[BUS_SIZE-1:0];
              wr_nonzero_data_o <= ld_nonzero_data_i[BUS_SIZE:1];
              wr_valid_o        <= 1'b1;
              wr_count_o        <= '0;
              ld_ready_o        <= 1'b0;
              state             <= SEND;
            end
          end
          SEND: begin
            ld_ready_o <= 1'b0;
            if (wr_valid_o && wr_ready_i) begin
              if (wr_count_o == LAST_BEAT) begin
                wr_valid_o <= 1'b0;
                wr_count_o <= '0;
                done_o     <= 1'b1;
                ld_ready_o <= 1'b1;
                state      <= IDLE;
              end else begin
                wr_count_o        <= next_count;
                wr_sparsemap_o    <= shadow_sm[BUS_SIZE*int'(next_count) +: BUS_SIZE];
                wr_nonzero_data_o <= shadow_data[BUS_SIZE*int'(next_count)+1 +: BUS_SIZE];
              end
            end
          end
          default: begin
            state      <= IDLE;
            ld_ready_o <= 1'b1;
            wr_valid_o <= 1'b0;
            wr_count_o <= '0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dat_chunk_tx.sv
// ============================================================================
// tb_dat_chunk_tx
// ----------------------------------------------------------------------------
// Directed self-checking bench for dat_chunk_tx (MEM_SIZE=512, BUS_SIZE=128).
// Ports: none.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dat_chunk_tx;

  localparam int MEM_SIZE = 512;
  localparam int BUS_SIZE = 128;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic                   ld_valid_i;
  logic                   ld_ready_o;
  logic [511:0]           ld_sparsemap_i;
  logic [512:1][7:0]      ld_nonzero_data_i;
  logic                   flush_i;
  logic                   wr_ready_i;
  logic                   wr_valid_o;
  logic [1:0]             wr_count_o;
  logic [127:0]           wr_sparsemap_o;
  logic [127:0][7:0]      wr_nonzero_data_o;
  logic [9:0]             nz_count_o;
  logic                   done_o;

  int vectors     = 0;
  int miscompares = 0;

  dat_chunk_tx #(.MEM_SIZE(MEM_SIZE), .BUS_SIZE(BUS_SIZE)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .ld_valid_i        (ld_valid_i),
    .ld_ready_o        (ld_ready_o),
    .ld_sparsemap_i    (ld_sparsemap_i),
    .ld_nonzero_data_i (ld_nonzero_data_i),
    .flush_i           (flush_i),
    .wr_ready_i        (wr_ready_i),
    .wr_valid_o        (wr_valid_o),
    .wr_count_o        (wr_count_o),
    .wr_sparsemap_o    (wr_sparsemap_o),
    .wr_nonzero_data_o (wr_nonzero_data_o),
    .nz_count_o        (nz_count_o),
    .done_o            (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Wide values are folded to 64 bits for printing; narrow ones print as-is.
  function automatic logic [63:0] fold(input logic [1023:0] v);
    logic [63:0] r = '0;
    for (int i = 0; i < 16; i++) r ^= v[64*i +: 64];
    return r;
  endfunction

  task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, fold(obs), fold(exp));
    end
  endtask

  function automatic logic [127:0] sm_slice(input logic [511:0] sm, input int b);
    logic [127:0] r;
    for (int j = 0; j < 128; j++) r[j] = sm[128*b + j];
    return r;
  endfunction

  function automatic logic [1023:0] nz_slice(input logic [512:1][7:0] d, input int b);
    logic [1023:0] r;
    for (int j = 0; j < 128; j++) r[8*j +: 8] = d[128*b + j + 1];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_beat(input string tag, input int b,
                            input logic [511:0] sm, input logic [512:1][7:0] d);
    check({tag, ".valid"}, 1024'(wr_valid_o), 1024'(1));
    check({tag, ".count"}, 1024'(wr_count_o), 1024'(b));
    check({tag, ".sm"},    1024'(wr_sparsemap_o), 1024'(sm_slice(sm, b)));
    check({tag, ".nz"},    1024'(wr_nonzero_data_o), nz_slice(d, b));
  endtask

  task automatic check_done(input string tag);
    check({tag, ".done"},     1024'(done_o), 1024'(1));
    check({tag, ".valid0"},   1024'(wr_valid_o), 1024'(0));
    check({tag, ".ldready"},  1024'(ld_ready_o), 1024'(1));
    check({tag, ".count0"},   1024'(wr_count_o), 1024'(0));
  endtask

  task automatic load(input logic [511:0] sm, input logic [512:1][7:0] d);
    ld_sparsemap_i    = sm;
    ld_nonzero_data_i = d;
    ld_valid_i        = 1'b1;
    tick();
    ld_valid_i        = 1'b0;
  endtask

  task automatic rand_image(output logic [511:0] sm, output logic [512:1][7:0] d);
    for (int w = 0; w < 16; w++) sm[32*w +: 32] = $urandom;
    for (int k = 1; k <= 512; k++) d[k] = 8'($urandom);
  endtask

  logic [511:0]      sm_a, sm_b;
  logic [512:1][7:0] img_a, img_b;
  logic [511:0]      cap_sm;
  logic [512:1][7:0] cap_data;
  bit                got_done;

  initial begin
    rst_i             = 1'b1;
    ld_valid_i        = 1'b0;
    ld_sparsemap_i    = '0;
    ld_nonzero_data_i = '0;
    flush_i           = 1'b0;
    wr_ready_i        = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst.ldready", 1024'(ld_ready_o), 1024'(1));
    check("rst.valid",   1024'(wr_valid_o), 1024'(0));
    check("rst.count",   1024'(wr_count_o), 1024'(0));
    check("rst.sm",      1024'(wr_sparsemap_o), 1024'(0));
    check("rst.nz",      1024'(wr_nonzero_data_o), 1024'(0));
    check("rst.nzcnt",   1024'(nz_count_o), 1024'(0));
    check("rst.done",    1024'(done_o), 1024'(0));
    rst_i = 1'b0;
    tick();

    // 1: all-ones sparsemap, data[k]=k[7:0], no backpressure
    sm_a = '1;
    for (int k = 1; k <= 512; k++) img_a[k] = 8'(k);
    load(sm_a, img_a);
    check("t1.nzcnt",   1024'(nz_count_o), 1024'(512));
    check("t1.ldready", 1024'(ld_ready_o), 1024'(0));
    check("t1.b0.d0",   1024'(wr_nonzero_data_o[0]), 1024'(8'h01));
    check_beat("t1.b0", 0, sm_a, img_a);
    tick();
    check_beat("t1.b1", 1, sm_a, img_a);
    tick();
    check("t1.b2.d0",   1024'(wr_nonzero_data_o[0]), 1024'(8'h01));
    check("t1.b2.d127", 1024'(wr_nonzero_data_o[127]), 1024'(8'h80));
    check("t1.b2.sm",   1024'(wr_sparsemap_o), 1024'({128{1'b1}}));
    check_beat("t1.b2", 2, sm_a, img_a);
    tick();
    check_beat("t1.b3", 3, sm_a, img_a);
    check("t1.b3.nodone", 1024'(done_o), 1024'(0));
    tick();
    check_done("t1");
    tick();
    check("t1.donepulse", 1024'(done_o), 1024'(0));

    // 2: three stall cycles on beat 1, 7 cycles total
    rand_image(sm_b, img_b);
    load(sm_b, img_b);
    check_beat("t2.b0", 0, sm_b, img_b);
    tick();
    check_beat("t2.b1", 1, sm_b, img_b);
    wr_ready_i = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      check_beat("t2.stall", 1, sm_b, img_b);
    end
    wr_ready_i = 1'b1;
    tick();
    check_beat("t2.b2", 2, sm_b, img_b);
    tick();
    check_beat("t2.b3", 3, sm_b, img_b);
    tick();
    check_done("t2");
    tick();

    // 3: flush while beat 2 is being accepted
    load(sm_a, img_a);
    tick();
    tick();
    check_beat("t3.b2", 2, sm_a, img_a);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("t3.valid0",  1024'(wr_valid_o), 1024'(0));
    check("t3.count0",  1024'(wr_count_o), 1024'(0));
    check("t3.nodone",  1024'(done_o), 1024'(0));
    check("t3.ldready", 1024'(ld_ready_o), 1024'(1));
    check("t3.nzkeep",  1024'(nz_count_o), 1024'(512));
    tick();
    check("t3.nodone2", 1024'(done_o), 1024'(0));
    // flush beats a simultaneous load
    ld_sparsemap_i    = sm_b;
    ld_nonzero_data_i = img_b;
    ld_valid_i        = 1'b1;
    flush_i           = 1'b1;
    tick();
    flush_i = 1'b0;
    check("t3.flushload.valid", 1024'(wr_valid_o), 1024'(0));
    check("t3.flushload.nz",    1024'(nz_count_o), 1024'(512));
    tick();
    ld_valid_i = 1'b0;
    check("t3.reload.nzcnt", 1024'(nz_count_o), 1024'($countones(sm_b)));
    check_beat("t3.reload.b0", 0, sm_b, img_b);
    for (int b = 1; b < 4; b++) tick();
    tick();
    check_done("t3.reload");
    tick();

    // 4: empty sparsemap
    sm_a = '0;
    load(sm_a, img_a);
    check("t4.nzcnt", 1024'(nz_count_o), 1024'(0));
    for (int b = 0; b < 4; b++) begin
      check("t4.sm0",   1024'(wr_sparsemap_o), 1024'(0));
      check("t4.count", 1024'(wr_count_o), 1024'(b));
      tick();
    end
    check_done("t4");
    tick();

    // 5: reassemble a random chunk from the beat stream
    rand_image(sm_b, img_b);
    cap_sm   = '0;
    cap_data = '0;
    got_done = 1'b0;
    load(sm_b, img_b);
    for (int cyc = 0; cyc < 20 && !got_done; cyc++) begin
      if (wr_valid_o && wr_ready_i) begin
        for (int j = 0; j < 128; j++) begin
          cap_sm[128*int'(wr_count_o) + j]       = wr_sparsemap_o[j];
          cap_data[128*int'(wr_count_o) + j + 1] = wr_nonzero_data_o[j];
        end
      end
      tick();
      if (done_o) got_done = 1'b1;
    end
    check("t5.done_seen", 1024'(got_done), 1024'(1));
    check("t5.nzcnt", 1024'(nz_count_o), 1024'($countones(sm_b)));
    for (int b = 0; b < 4; b++) begin
      check("t5.sm",   1024'(sm_slice(cap_sm, b)), 1024'(sm_slice(sm_b, b)));
      check("t5.data", nz_slice(cap_data, b), nz_slice(img_b, b));
    end
    tick();

    // 6: reset mid-SEND with a load held through reset
    rand_image(sm_a, img_a);
    rand_image(sm_b, img_b);
    load(sm_a, img_a);
    tick();
    check_beat("t6.b1", 1, sm_a, img_a);
    rst_i             = 1'b1;
    ld_sparsemap_i    = sm_b;
    ld_nonzero_data_i = img_b;
    ld_valid_i        = 1'b1;
    tick();
    rst_i = 1'b0;
    check("t6.ldready", 1024'(ld_ready_o), 1024'(1));
    check("t6.valid",   1024'(wr_valid_o), 1024'(0));
    check("t6.count",   1024'(wr_count_o), 1024'(0));
    check("t6.sm",      1024'(wr_sparsemap_o), 1024'(0));
    check("t6.nz",      1024'(wr_nonzero_data_o), 1024'(0));
    check("t6.nzcnt",   1024'(nz_count_o), 1024'(0));
    check("t6.done",    1024'(done_o), 1024'(0));
    tick();
    ld_valid_i = 1'b0;
    check("t6.reload.nzcnt", 1024'(nz_count_o), 1024'($countones(sm_b)));
    check_beat("t6.reload.b0", 0, sm_b, img_b);
    for (int b = 1; b < 4; b++) begin
      tick();
      check_beat("t6.reload.bn", b, sm_b, img_b);
    end
    tick();
    check_done("t6");
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dat_chunk_tx.md
Name: dat_chunk_tx

Overview:
- Transmit side of the chunk write interface.
- Accepts one complete compressed chunk image in a single load handshake:
  - sparsemap, MEM_SIZE bits
  - compacted nonzero byte array, indexed 1..MEM_SIZE
- Streams the image out as MEM_SIZE/BUS_SIZE bus beats, each carrying a sparsemap slice, a nonzero-data slice and a beat count.
- Output is the wr_* interface consumed by the chunk combining buffer. Sits between the compressor/loader and the per-PE chunk buffers.

Parameters:
- MEM_SIZE, default `MEM_SIZE (512): chunk size in bytes, which is also the number of sparsemap bits.
- BUS_SIZE, default `BUS_SIZE (128): bytes per bus beat. MEM_SIZE must be an integer multiple of BUS_SIZE.
- BEAT_NUM, localparam = MEM_SIZE/BUS_SIZE: number of beats per chunk.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- ld_valid_i  in  1  a chunk image is offered.
- ld_ready_o  out  1  block can accept a chunk.
- ld_sparsemap_i  in  [MEM_SIZE-1:0]  chunk sparsemap.
- ld_nonzero_data_i  in  [MEM_SIZE:1][7:0]  compacted nonzero bytes, index 1-based.
- flush_i  in  1  abort the current transfer.
- wr_ready_i  in  1  downstream accepts the current beat. Tie to 1 for a sink without backpressure.
- wr_valid_o  out  1  beat valid.
- wr_count_o  out  [$clog2(BEAT_NUM)-1:0]  beat index.
- wr_sparsemap_o  out  [BUS_SIZE-1:0]  sparsemap slice.
- wr_nonzero_data_o  out  [BUS_SIZE-1:0][7:0]  nonzero-data slice.
- nz_count_o  out  [$clog2(MEM_SIZE+1)-1:0]  popcount of the loaded sparsemap.
- done_o  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- All outputs are registered. Reset values:
  - ld_ready_o=1
  - wr_valid_o=0, wr_count_o=0
  - wr_sparsemap_o=0, wr_nonzero_data_o=0
  - nz_count_o=0, done_o=0
  - state=IDLE
  - shadow sparsemap and shadow data registers cleared to 0
- FSM states: IDLE, SEND.
- IDLE:
  - ld_ready_o=1.
  - On ld_valid_i & ld_ready_o: capture both inputs into shadow registers, register nz_count_o = popcount(ld_sparsemap_i), go to SEND with count=0.
  - wr_valid_o rises the cycle after the load handshake (load-to-first-beat latency 1).
- SEND:
  - ld_ready_o=0, wr_valid_o=1.
  - wr_sparsemap_o = shadow_sparsemap[BUS_SIZE*count +: BUS_SIZE].
  - wr_nonzero_data_o = shadow_data[(BUS_SIZE*count+1) +: BUS_SIZE].
  - Beat accepted when wr_valid_o & wr_ready_i:
    - If count < BEAT_NUM-1: count increments.
    - If count == BEAT_NUM-1: next cycle wr_valid_o=0, done_o=1, count=0, state=IDLE, ld_ready_o=1.
  - While wr_ready_i=0: all wr_* outputs hold stable (no change of data while valid and not ready).
- Back-to-back chunks: ld_ready_o is not asserted during SEND. Minimum gap between chunks is one cycle, the IDLE cycle coinciding with done_o.
- nz_count_o holds its value until the next load.
- Flush:
  - flush_i in any state forces IDLE next cycle: wr_valid_o=0, count=0, done_o=0.
  - Shadow registers and nz_count_o are unchanged.
  - flush_i has priority over the load handshake and over beat acceptance in the same cycle.
- rst_i during SEND: same effect as reset values. Any partial transfer is discarded; no done_o is generated.
- ld_valid_i while in SEND is ignored; the loader must hold it until ld_ready_o.
- Popcount is a pure adder tree over MEM_SIZE bits. Result width $clog2(MEM_SIZE+1), so the all-ones sparsemap gives 512 without overflow.

Decomposition:
- Shared package chunk_pkg:
  - localparam BEAT_NUM, CNT_W=$clog2(BEAT_NUM), NZC_W=$clog2(MEM_SIZE+1)
  - typedef of the state enum {IDLE, SEND}
  - typedefs for sparsemap_t [MEM_SIZE-1:0] and chunk_data_t [MEM_SIZE:1][7:0]
- Reuse the package in the receiving chunk buffer.
- One sub-module: popcount_tree (parameter WIDTH), used here for nz_count_o and reusable by the sparse-match logic.

Test Plan (MEM_SIZE=512, BUS_SIZE=128, BEAT_NUM=4):
1. Load with sparsemap=all ones and data[k]=k[7:0], wr_ready_i=1 -> counts 0,1,2,3 on 4 consecutive cycles; beat 2 data[0]=8'h01 (index 257); sparsemap slice 128'hFF..FF; nz_count_o=512; done_o pulses 1 cycle after beat 3; ld_ready_o=1 with done_o.
2. wr_ready_i low for 3 cycles during beat 1 -> count stays 1 and slices unchanged for 3 cycles; transfer completes in 7 cycles; no beat duplicated or skipped.
3. flush_i asserted in the cycle count=2 is accepted -> next cycle wr_valid_o=0, count=0, no done_o; the next load restarts at count 0.
4. Load with sparsemap=0 -> 4 beats of zero sparsemap, nz_count_o=0, done_o pulses.
5. Connect to the chunk combining buffer with wr_ready_i=1, random chunk -> buffer's rd_sparsemap/rd_nonzero_data equal the loaded image bit-for-bit after done_o.
6. rst_i asserted mid-SEND at count=1 -> next cycle all outputs at reset values, ld_ready_o=1; ld_valid_i held through reset is accepted on the first cycle after rst_i deasserts.
